// File: rtl/dtc_feature_streamer_if.sv
// Handshake bundle between the feature pipeline, the streamer and the result consumer.
// The streamer uses the slave modport; the feature source/result sink uses master.
interface dtc_feature_streamer_if #(
   parameter int N_FEAT = 12,
   parameter int N_CLS  = 3
);
   logic              s_valid;
   logic              s_ready;
   logic              s_bit;
   logic              s_abort;
   logic              m_valid;
   logic              m_ready;
   logic [N_CLS-1:0]  m_class;
   logic [N_FEAT-1:0] m_feat;

   modport master (
      output s_valid, s_bit, s_abort, m_ready,
      input  s_ready, m_valid, m_class, m_feat
   );

   modport slave (
      input  s_valid, s_bit, s_abort, m_ready,
      output s_ready, m_valid, m_class, m_feat
   );
endinterface

// File: rtl/dtc_feature_streamer.sv
// Deserialises a bit-serial feature vector for a combinational decision-tree classifier,
// registers the returned label, hands it downstream and keeps a saturating class histogram.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_SHIFT | accepting feature bits LSB-first into the shift register
// ST_EVAL  | one cycle, classifier sees the stable vector, label captured
// ST_HOLD  | result presented on m_*, waiting for m_ready
module dtc_feature_streamer #(
   parameter int N_FEAT = 12,
   parameter int N_CLS  = 3,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   dtc_feature_streamer_if.slave io,
   output logic [N_FEAT-1:0]     cls_inp,
   input  logic [N_CLS-1:0]      cls_outp,
   input  logic                  clr_cnt,
   input  logic [N_CLS-1:0]      cnt_sel,
   output logic [CNT_W-1:0]      cnt_val
);
   localparam int BC_W  = $clog2(N_FEAT);
   localparam int N_BIN = 1 << N_CLS;

   localparam logic [1:0] ST_SHIFT = 2'd0;
   localparam logic [1:0] ST_EVAL  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam logic [BC_W-1:0]  BC_LAST = BC_W'(N_FEAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]        state_q, state_d;
   logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
   logic [N_FEAT-1:0] shreg_q, shreg_d;
   logic [N_FEAT-1:0] cls_inp_q, cls_inp_d;
   logic              s_ready_q, s_ready_d;
   logic              m_valid_q, m_valid_d;
   logic [N_CLS-1:0]  m_class_q, m_class_d;
   logic [N_FEAT-1:0] m_feat_q, m_feat_d;
   logic [CNT_W-1:0]  cnt_q [N_BIN];
   logic [CNT_W-1:0]  cnt_d [N_BIN];
   logic [CNT_W-1:0]  cnt_val_q, cnt_val_d;

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      cls_inp_d = cls_inp_q;
      m_valid_d = m_valid_q;
      m_class_d = m_class_q;
      m_feat_d  = m_feat_q;

      case (state_q)
         ST_SHIFT: begin
            if (io.s_abort) begin
               bitcnt_d = '0;
            end else if (io.s_valid && s_ready_q) begin
               shreg_d[bitcnt_q] = io.s_bit;
               if (bitcnt_q == BC_LAST) begin
                  cls_inp_d = shreg_d;
                  bitcnt_d  = '0;
                  state_d   = ST_EVAL;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         ST_EVAL: begin
            m_class_d = cls_outp;
            m_feat_d  = cls_inp_q;
            m_valid_d = 1'b1;
            state_d   = ST_HOLD;
         end
         ST_HOLD: begin
            if (io.m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         default: state_d = ST_SHIFT;
      endcase

      // s_ready is registered so it is low throughout reset and rises with the SHIFT entry
      s_ready_d = (state_d == ST_SHIFT);
   end

   always_comb begin
      for (int i = 0; i < N_BIN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr_cnt) begin
            cnt_d[i] = '0;
         end else if (state_q == ST_EVAL && cls_outp == N_CLS'(i) && cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      cnt_val_d = cnt_q[cnt_sel];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_SHIFT;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
         cls_inp_q <= '0;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         m_class_q <= '0;
         m_feat_q  <= '0;
         cnt_val_q <= '0;
         for (int i = 0; i < N_BIN; i++) cnt_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
         cls_inp_q <= cls_inp_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_class_q <= m_class_d;
         m_feat_q  <= m_feat_d;
         cnt_val_q <= cnt_val_d;
         for (int i = 0; i < N_BIN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign io.s_ready = s_ready_q;
   assign io.m_valid = m_valid_q;
   assign io.m_class = m_class_q;
   assign io.m_feat  = m_feat_q;
   assign cls_inp    = cls_inp_q;
   assign cnt_val    = cnt_val_q;
endmodule

// File: tb/tb_dtc_feature_streamer.sv
// Self-checking bench for dtc_feature_streamer with a stub classifier (label = cls_inp[2:0]).
// A queue of expected vectors and a per-class histogram model are checked against the DUT.
module tb_dtc_feature_streamer;
   localparam int N_FEAT = 12;
   localparam int N_CLS  = 3;
   localparam int CNT_W  = 4;
   localparam int SAT    = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dtc_feature_streamer_if #(.N_FEAT(N_FEAT), .N_CLS(N_CLS)) io ();

   logic [N_FEAT-1:0] cls_inp;
   logic [N_CLS-1:0]  cls_outp;
   logic              clr_cnt;
   logic [N_CLS-1:0]  cnt_sel;
   logic [CNT_W-1:0]  cnt_val;

   assign cls_outp = cls_inp[2:0];

   dtc_feature_streamer #(.N_FEAT(N_FEAT), .N_CLS(N_CLS), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io       (io),
      .cls_inp  (cls_inp),
      .cls_outp (cls_outp),
      .clr_cnt  (clr_cnt),
      .cnt_sel  (cnt_sel),
      .cnt_val  (cnt_val)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   bit rst_smp = 1'b0;
   bit mv_prev = 1'b0;
   logic [N_FEAT-1:0] exp_q [$];
   int hist [8];
   int mv_cyc [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= rst_n;
   end

   // Continuous compare against the expected-result queue
   always @(negedge clk) begin
      if (!rst_smp) begin
         chk("rst_s_ready", {31'd0, io.s_ready}, 0);
         chk("rst_m_valid", {31'd0, io.m_valid}, 0);
         chk("rst_m_class", {29'd0, io.m_class}, 0);
         chk("rst_m_feat", {20'd0, io.m_feat}, 0);
         chk("rst_cls_inp", {20'd0, cls_inp}, 0);
         chk("rst_cnt_val", {28'd0, cnt_val}, 0);
         mv_prev = 1'b0;
      end else begin
         if (io.m_valid) begin
            if (!mv_prev) mv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("spurious_m_valid", {31'd0, io.m_valid}, 0);
            end else begin
               chk("m_feat", {20'd0, io.m_feat}, {20'd0, exp_q[0]});
               chk("m_class", {29'd0, io.m_class}, {29'd0, exp_q[0][2:0]});
               chk("cls_inp_hold", {20'd0, cls_inp}, {20'd0, exp_q[0]});
               chk("s_ready_in_hold", {31'd0, io.s_ready}, 0);
               if (io.m_ready) void'(exp_q.pop_front());
            end
         end
         mv_prev = io.m_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_push(input logic [N_FEAT-1:0] v);
      exp_q.push_back(v);
      if (hist[v[2:0]] < SAT) hist[v[2:0]]++;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) hist[i] = 0;
   endtask

   task automatic send_bits(input logic [N_FEAT-1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         io.s_valid = 1'b1;
         io.s_bit   = v[i];
         t = 0;
         while (!io.s_ready && t < 100) begin
            tick();
            t++;
         end
         if (t >= 100) begin
            chk("s_ready_timeout", {31'd0, io.s_ready}, 1);
            return;
         end
         tick();
      end
   endtask

   task automatic send_vec(input logic [N_FEAT-1:0] v, input bit keep);
      send_bits(v, N_FEAT);
      model_push(v);
      if (!keep) io.s_valid = 1'b0;
   endtask

   task automatic wait_mvalid();
      int t = 0;
      while (!io.m_valid && t < 50) begin
         tick();
         t++;
      end
      chk("m_valid_timeout", {31'd0, io.m_valid}, 1);
   endtask

   task automatic check_bins(input string tag);
      for (int b = 0; b < 8; b++) begin
         cnt_sel = 3'(b);
         tick();
         chk($sformatf("%s_bin%0d", tag, b), {28'd0, cnt_val}, 32'(hist[b]));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      io.s_valid = 1'b0;
      io.s_bit   = 1'b0;
      io.s_abort = 1'b0;
      io.m_ready = 1'b0;
      clr_cnt    = 1'b0;
      cnt_sel    = '0;
      model_clear();

      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("s_ready_after_release", {31'd0, io.s_ready}, 1);

      // basic vector with latency pins
      io.m_ready = 1'b1;
      send_bits(12'hABC, N_FEAT);
      chk("basic_cls_inp", {20'd0, cls_inp}, 32'hABC);
      chk("basic_m_valid_in_eval", {31'd0, io.m_valid}, 0);
      model_push(12'hABC);
      io.s_valid = 1'b0;
      tick();
      chk("basic_m_valid", {31'd0, io.m_valid}, 1);
      chk("basic_m_class", {29'd0, io.m_class}, 32'h4);
      chk("basic_m_feat", {20'd0, io.m_feat}, 32'hABC);
      tick();
      chk("basic_m_valid_drop", {31'd0, io.m_valid}, 0);
      chk("basic_s_ready_back", {31'd0, io.s_ready}, 1);
      cnt_sel = 3'd4;
      tick();
      chk("basic_bin4_literal", {28'd0, cnt_val}, 1);
      check_bins("basic");

      // backpressure
      io.m_ready = 1'b0;
      send_vec(12'h3C5, 1'b1);
      wait_mvalid();
      for (int k = 0; k < 5; k++) begin
         chk("bp_s_ready", {31'd0, io.s_ready}, 0);
         chk("bp_m_valid", {31'd0, io.m_valid}, 1);
         chk("bp_m_feat", {20'd0, io.m_feat}, 32'h3C5);
         tick();
      end
      io.s_valid = 1'b0;
      io.m_ready = 1'b1;
      tick();
      chk("bp_s_ready_release", {31'd0, io.s_ready}, 1);
      chk("bp_m_valid_release", {31'd0, io.m_valid}, 0);

      // throughput: 4 back-to-back vectors
      mv_cyc.delete();
      send_vec(12'h123, 1'b1);
      send_vec(12'h456, 1'b1);
      send_vec(12'h78E, 1'b1);
      send_vec(12'hFE7, 1'b0);
      wait_mvalid();
      repeat (3) tick();
      chk("tp_pulse_count", 32'(mv_cyc.size()), 4);
      if (mv_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("tp_period", 32'(mv_cyc[i] - mv_cyc[i-1]), 14);
      end
      chk("tp_drained", 32'(exp_q.size()), 0);
      check_bins("tp");

      // abort
      send_bits(12'hFFF, 5);
      io.s_abort = 1'b1;
      io.s_valid = 1'b1;
      io.s_bit   = 1'b1;
      tick();
      io.s_abort = 1'b0;
      send_vec(12'h001, 1'b0);
      wait_mvalid();
      chk("abort_m_feat", {20'd0, io.m_feat}, 32'h001);
      repeat (2) tick();
      cnt_sel = 3'd1;
      tick();
      chk("abort_bin1_literal", {28'd0, cnt_val}, 1);
      check_bins("abort");

      // reset in the middle of a vector
      send_bits(12'h0F3, 7);
      io.s_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      exp_q.delete();
      model_clear();
      rst_n = 1'b1;
      tick();
      send_vec(12'h5A5, 1'b0);
      wait_mvalid();
      chk("rst_m_feat_literal", {20'd0, io.m_feat}, 32'h5A5);
      repeat (2) tick();
      cnt_sel = 3'd5;
      tick();
      chk("rst_bin5_literal", {28'd0, cnt_val}, 1);
      check_bins("rst");

      // saturation and clear-wins
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      model_clear();
      for (int k = 0; k < 17; k++) send_vec(12'(k * 8 + 2), 1'b0);
      repeat (3) tick();
      cnt_sel = 3'd2;
      tick();
      chk("sat_bin2_literal", {28'd0, cnt_val}, 15);
      check_bins("sat");
      send_bits(12'h0AA, N_FEAT);
      model_push(12'h0AA);
      io.s_valid = 1'b0;
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      model_clear();
      repeat (2) tick();
      cnt_sel = 3'd2;
      tick();
      chk("clr_bin2_literal", {28'd0, cnt_val}, 0);
      check_bins("clr");

      chk("final_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
